// File: rtl/tick_scheduler_pkg.sv
// Shared types and width helpers for the tick scheduler time base.
package tick_scheduler_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_e;

    // Channel-select width; a single channel still needs a one-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_CH_DEFAULT = 4;
    localparam int CH_W         = ch_width(N_CH_DEFAULT);

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_in by PRESCALE into a registered one-cycle base tick.
module tick_prescaler #(
    parameter int PRESCALE = 100
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic base_tick
);

    localparam int              PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_r;
    logic            base_tick_r;

    // Wrapping counter; the pulse follows the cycle that holds the terminal count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            base_tick_r <= 1'b0;
        end else begin
            base_tick_r <= (cnt_r == LAST);
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + PS_W'(1);
            end
        end
    end

    assign base_tick = base_tick_r;

endmodule

// File: rtl/tick_scheduler.sv
// Shared prescaler feeding N programmable period channels; divisor updates
// are held pending and applied only at a channel boundary.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int PRESCALE    = 100,
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           ch_en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_width(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic                      cfg_err,
    output logic                      base_tick,
    output logic [N_CH-1:0]           tick,
    output logic [N_CH-1:0]           tog
);

    localparam int CW = ch_width(N_CH);

    logic             base_tick_s;
    logic [N_CH-1:0]  stop_s;
    logic [N_CH-1:0]  wrap_s;
    logic             accept_s;
    logic             bad_ch_s;
    logic             apply_s;

    cfg_state_e       state_r;
    logic [CW-1:0]    pend_ch_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             cfg_ready_r;
    logic             cfg_err_r;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .base_tick (base_tick_s)
    );

    assign accept_s = cfg_valid && cfg_ready_r;
    assign bad_ch_s = ({1'b0, cfg_ch} >= (CW + 1)'(N_CH));
    // A stopped channel has no boundary to wait for, so it takes the update at once.
    assign apply_s  = (state_r == PENDING) && (stop_s[pend_ch_r] || wrap_s[pend_ch_r]);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_r;
        logic [DIV_W-1:0] cnt_r;
        logic             tick_r;
        logic             tog_r;
        logic             apply_here_s;

        assign stop_s[i]    = !ch_en[i] || (div_r == '0);
        assign wrap_s[i]    = !stop_s[i] && base_tick_s && (cnt_r == div_r - DIV_W'(1));
        assign apply_here_s = apply_s && (pend_ch_r == CW'(i));

        // Per-channel base-tick counter; the wrap tick always uses the period that just ended.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                div_r  <= DIV_W'(DEFAULT_DIV);
                cnt_r  <= '0;
                tick_r <= 1'b0;
                tog_r  <= 1'b0;
            end else begin
                tick_r <= wrap_s[i];
                tog_r  <= tog_r ^ wrap_s[i];
                if (apply_here_s) begin
                    div_r <= pend_div_r;
                    cnt_r <= '0;
                end else if (stop_s[i] || wrap_s[i]) begin
                    cnt_r <= '0;
                end else if (base_tick_s) begin
                    cnt_r <= cnt_r + DIV_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end

        assign tick[i] = tick_r;
        assign tog[i]  = tog_r;
    end

    // Config FSM: one outstanding update, out-of-range channels rejected with an error pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pend_ch_r   <= '0;
            pend_div_r  <= '0;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && bad_ch_s) begin
                        cfg_err_r <= 1'b1;
                    end else if (accept_s) begin
                        pend_ch_r   <= cfg_ch;
                        pend_div_r  <= cfg_div;
                        cfg_ready_r <= 1'b0;
                        state_r     <= PENDING;
                    end else begin
                        cfg_ready_r <= 1'b1;
                    end
                end
                PENDING: begin
                    if (apply_s) begin
                        cfg_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        cfg_ready_r <= 1'b0;
                    end
                end
                default: begin
                    cfg_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign base_tick = base_tick_s;
    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised scoreboard bench for tick_scheduler against a base-tick counting model.
module tb_tick_scheduler;
    import tick_scheduler_pkg::*;

    localparam int P     = 4;
    localparam int N_CH  = 3;
    localparam int DIV_W = 8;
    localparam int DEFD  = 3;
    localparam int CW    = ch_width(N_CH);

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b1;
    logic [N_CH-1:0]  ch_en  = '1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_ch  = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_err;
    logic             base_tick;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  tog;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycle 1 is the cycle in which reset is released.
    int              cyc;
    int              m_div  [N_CH];
    int              m_seen [N_CH];
    logic [N_CH-1:0] m_tog;
    bit              m_pend;
    int              m_pch;
    int              m_pdiv;
    int              tick_q [N_CH][$];
    int              bt_q[$];
    int              err_q[$];

    tick_scheduler #(
        .PRESCALE    (P),
        .N_CH        (N_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFD)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .base_tick (base_tick),
        .tick      (tick),
        .tog       (tog)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Base ticks are high in cycles P+1, 2P+1, ... counted from reset release.
    function automatic bit bt_at(input int c);
        return (c > P) && (((c - 1) % P) == 0);
    endfunction

    task automatic model_reset();
        cyc    = 1;
        m_tog  = '0;
        m_pend = 1'b0;
        m_pch  = 0;
        m_pdiv = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_div[i]  = DEFD;
            m_seen[i] = 0;
            tick_q[i].delete();
        end
        bt_q.delete();
        err_q.delete();
    endtask

    // Reference model: counts base ticks per channel and predicts next-cycle events.
    initial begin : model_p
        logic [N_CH-1:0] run;
        logic [N_CH-1:0] wrap;
        bit              bt;
        forever begin
            @(posedge clk_in);
            if (rst_n) begin
                bt = bt_at(cyc);
                for (int i = 0; i < N_CH; i++) begin
                    run[i]  = ch_en[i] && (m_div[i] != 0);
                    wrap[i] = run[i] && bt && (m_seen[i] + 1 == m_div[i]);
                    if (wrap[i]) begin
                        tick_q[i].push_back(cyc + 1);
                        m_tog[i] = ~m_tog[i];
                    end
                    if (!run[i] || wrap[i]) m_seen[i] = 0;
                    else if (bt) m_seen[i] = m_seen[i] + 1;
                end
                if (m_pend) begin
                    if (!run[m_pch] || wrap[m_pch]) begin
                        m_div[m_pch]  = m_pdiv;
                        m_seen[m_pch] = 0;
                        m_pend        = 1'b0;
                    end
                end else if (cfg_valid) begin
                    if (int'(cfg_ch) >= N_CH) begin
                        err_q.push_back(cyc + 1);
                    end else begin
                        m_pend = 1'b1;
                        m_pch  = int'(cfg_ch);
                        m_pdiv = int'(cfg_div);
                    end
                end
                if (bt_at(cyc + 1)) bt_q.push_back(cyc + 1);
                cyc = cyc + 1;
            end
        end
    end

    // Monitor: pops expected events for the current cycle and compares every output.
    initial begin : monitor_p
        bit exp_b;
        forever begin
            @(negedge clk_in);
            if (rst_n) begin
                for (int i = 0; i < N_CH; i++) begin
                    exp_b = (tick_q[i].size() != 0) && (tick_q[i][0] == cyc);
                    if (exp_b) void'(tick_q[i].pop_front());
                    chk(tick[i] == exp_b, $sformatf("tick%0d", i), int'(tick[i]), int'(exp_b));
                end
                exp_b = (bt_q.size() != 0) && (bt_q[0] == cyc);
                if (exp_b) void'(bt_q.pop_front());
                chk(base_tick == exp_b, "base_tick", int'(base_tick), int'(exp_b));
                exp_b = (err_q.size() != 0) && (err_q[0] == cyc);
                if (exp_b) void'(err_q.pop_front());
                chk(cfg_err == exp_b, "cfg_err", int'(cfg_err), int'(exp_b));
                chk(cfg_ready == !m_pend, "cfg_ready", int'(cfg_ready), int'(!m_pend));
                chk(tog == m_tog, "tog", int'(tog), int'(m_tog));
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk(tick == '0, "rst_tick", int'(tick), 0);
        chk(tog == '0, "rst_tog", int'(tog), 0);
        chk(base_tick == 1'b0, "rst_base_tick", int'(base_tick), 0);
        chk(cfg_err == 1'b0, "rst_cfg_err", int'(cfg_err), 0);
        chk(cfg_ready == 1'b1, "rst_cfg_ready", int'(cfg_ready), 1);
        model_reset();
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_cfg(input int ch, input int dv);
        int n = 0;
        cfg_ch    = CW'(ch);
        cfg_div   = DIV_W'(dv);
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk(cfg_ready == 1'b1, "cfg_accept_wait", n, 200);
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk(cfg_ready == 1'b1, "ready_wait", n, 200);
    endtask

    task automatic wait_tick(input int ch);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[ch] && n < 300);
        chk(tick[ch] == 1'b1, "tick_wait", n, 300);
    endtask

    task automatic wait_bt();
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!base_tick && n < 50);
        chk(base_tick == 1'b1, "bt_wait", n, 50);
    endtask

    initial begin : main_p
        int  idx;
        int  held;
        int  exp_c;
        int  nbt;
        bit  rdy_prev;

        #2;
        apply_reset();

        // Default divisor 3: first tick at P*3+2, then period 12.
        wait_tick(0);
        chk(cyc == P * DEFD + 2, "first_tick0", cyc, P * DEFD + 2);

        // Reconfigure channel 0 one base tick into its period.
        wait_bt();
        send_cfg(0, 5);
        wait_tick(0);
        chk(cyc == 26, "reconf_old_tick", cyc, 26);
        wait_tick(0);
        chk(cyc == 46, "reconf_new_period", cyc, 46);

        // Update to a disabled channel completes two cycles after the handshake.
        ch_en[2] = 1'b0;
        send_cfg(2, 7);
        chk(cfg_ready == 1'b0, "dis_ready_low", int'(cfg_ready), 0);
        @(negedge clk_in);
        chk(cfg_ready == 1'b1, "dis_ready_back", int'(cfg_ready), 1);

        // Out-of-range channel select.
        send_cfg(3, 4);
        chk(cfg_err == 1'b1, "bad_ch_err", int'(cfg_err), 1);
        chk(cfg_ready == 1'b1, "bad_ch_ready", int'(cfg_ready), 1);
        @(negedge clk_in);
        chk(cfg_err == 1'b0, "bad_ch_err_pulse", int'(cfg_err), 0);
        ch_en[2] = 1'b1;

        // Drop channel 1 exactly in its wrap cycle (one cycle before its next tick).
        wait_tick(1);
        repeat (P * DEFD - 1) @(negedge clk_in);
        ch_en[1] = 1'b0;
        held = int'(tog[1]);
        repeat (20) @(negedge clk_in);
        chk(int'(tog[1]) == held, "dis_tog_held", int'(tog[1]), held);
        ch_en[1] = 1'b1;
        exp_c = cyc;
        nbt   = 0;
        while (nbt < DEFD) begin
            if (bt_at(exp_c)) nbt++;
            if (nbt < DEFD) exp_c++;
        end
        wait_tick(1);
        chk(cyc == exp_c + 1, "reenable_first_tick", cyc, exp_c + 1);

        // Randomised traffic: enable toggles plus back-to-back config requests.
        rdy_prev = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk_in);
            if (cfg_valid && rdy_prev) cfg_valid = 1'b0;
            if (!cfg_valid && $urandom_range(0, 7) == 0) begin
                cfg_ch    = CW'($urandom_range(0, 3));
                cfg_div   = DIV_W'($urandom_range(0, 6));
                cfg_valid = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                idx        = int'($urandom_range(0, N_CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
            rdy_prev = cfg_ready;
        end
        @(negedge clk_in);
        cfg_valid = 1'b0;
        ch_en     = '1;
        wait_ready();

        // Reset while an update is pending returns everything to defaults.
        send_cfg(0, 5);
        wait_ready();
        wait_tick(0);
        send_cfg(0, 2);
        repeat (2) @(negedge clk_in);
        chk(cfg_ready == 1'b0, "pending_before_reset", int'(cfg_ready), 0);
        #2;
        apply_reset();
        wait_tick(0);
        chk(cyc == P * DEFD + 2, "post_reset_first_tick", cyc, P * DEFD + 2);
        repeat (40) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
